// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants and helpers for the ID-stage hazard controller.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [4:0] REG_ZERO        = 5'h0;
    localparam int         MULT_CYCLES_DEF = 4;
    localparam int         DIV_CYCLES_DEF  = 32;

    // $zero is hardwired, so a producer writing it never hazards.
    function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] src);
        return (rd != REG_ZERO) && (rd == src);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_fsm.sv
// MULT/DIV occupancy tracker: IDLE -> BUSY (N-1 cycles) -> DONE (1 cycle) -> IDLE.
// Busy/done flags are registered from the next state so they line up with r_state.
module md_busy_fsm
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_start,
    input  logic      i_is_div,
    output md_state_e o_state,
    output logic      o_busy,
    output logic      o_done
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != MD_IDLE);
            r_done  <= (w_state_nxt == MD_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MD_IDLE: begin
                if (i_start) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = i_is_div ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_BUSY: begin
                // Decrement only while non-zero, so the counter cannot wrap.
                if (r_cnt == '0) begin
                    w_state_nxt = MD_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            MD_DONE: begin
                w_state_nxt = MD_IDLE;
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_state = r_state;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use, branch-operand and MULT/DIV occupancy stalls.
// Stall/bubble/flush/start are combinational in the same cycle; MD_Busy/MD_Done are registered.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_RS,
    input  logic [4:0] ID_RT,
    input  logic       ID_UsesRT,
    input  logic       ID_Branch,
    input  logic       ID_BranchTaken,
    input  logic       ID_MulDiv,
    input  logic       ID_IsDiv,
    input  logic       ID_ReadHiLo,
    input  logic       EX_MemRead,
    input  logic       EX_RegWrite,
    input  logic [4:0] EX_RD,
    input  logic       MEM_MemRead,
    input  logic [4:0] MEM_RD,
    output logic       PC_Stall,
    output logic       IFID_Stall,
    output logic       IDEX_Bubble,
    output logic       IFID_Flush,
    output logic       MD_Start,
    output logic       MD_Busy,
    output logic       MD_Done
);

    md_state_e w_md_state;
    logic      w_lu;
    logic      w_br;
    logic      w_md;
    logic      w_stall;
    logic      w_start;

    assign w_lu = EX_MemRead &
                  (reg_hit(EX_RD, ID_RS) | (ID_UsesRT & reg_hit(EX_RD, ID_RT)));

    // Branches compare in ID, so even an ALU result still in EX is too late to forward.
    assign w_br = ID_Branch &
                  ((EX_RegWrite & (reg_hit(EX_RD, ID_RS) | reg_hit(EX_RD, ID_RT))) |
                   (MEM_MemRead & (reg_hit(MEM_RD, ID_RS) | reg_hit(MEM_RD, ID_RT))));

    assign w_md    = (ID_ReadHiLo | ID_MulDiv) & (w_md_state != MD_IDLE);
    assign w_stall = w_lu | w_br | w_md;
    assign w_start = ID_MulDiv & (w_md_state == MD_IDLE) & ~w_stall;

    assign PC_Stall    = w_stall;
    assign IFID_Stall  = w_stall;
    assign IDEX_Bubble = w_stall;
    assign IFID_Flush  = ID_Branch & ID_BranchTaken & ~w_stall;
    assign MD_Start    = w_start;

    md_busy_fsm #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_fsm (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
        .i_is_div (ID_IsDiv),
        .o_state  (w_md_state),
        .o_busy   (MD_Busy),
        .o_done   (MD_Done)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench; expected output vector is {PC_Stall,IFID_Stall,IDEX_Bubble,IFID_Flush,MD_Start,MD_Busy,MD_Done}.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_RS, ID_RT, EX_RD, MEM_RD;
    logic       ID_UsesRT, ID_Branch, ID_BranchTaken, ID_MulDiv, ID_IsDiv, ID_ReadHiLo;
    logic       EX_MemRead, EX_RegWrite, MEM_MemRead;
    logic       PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush, MD_Start, MD_Busy, MD_Done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_UsesRT(ID_UsesRT),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
        .ID_MulDiv(ID_MulDiv), .ID_IsDiv(ID_IsDiv), .ID_ReadHiLo(ID_ReadHiLo),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_RD(EX_RD),
        .MEM_MemRead(MEM_MemRead), .MEM_RD(MEM_RD),
        .PC_Stall(PC_Stall), .IFID_Stall(IFID_Stall), .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush), .MD_Start(MD_Start), .MD_Busy(MD_Busy), .MD_Done(MD_Done)
    );

    task automatic clr();
        ID_RS = 5'd0; ID_RT = 5'd0; EX_RD = 5'd0; MEM_RD = 5'd0;
        ID_UsesRT = 1'b0; ID_Branch = 1'b0; ID_BranchTaken = 1'b0;
        ID_MulDiv = 1'b0; ID_IsDiv = 1'b0; ID_ReadHiLo = 1'b0;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; MEM_MemRead = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        #1;
        obs = {PC_Stall, IFID_Stall, IDEX_Bubble, IFID_Flush, MD_Start, MD_Busy, MD_Done};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        clr();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_idle", 7'b0000000);

        EX_MemRead = 1'b1; EX_RD = 5'd8; ID_RS = 5'd8;
        chk("lu_rs", 7'b1110000);
        tick();
        EX_RD = 5'd0; ID_RS = 5'd0;
        chk("lu_r0", 7'b0000000);
        tick();
        EX_RD = 5'd9; ID_RT = 5'd9; ID_UsesRT = 1'b0;
        chk("lu_rt_unused", 7'b0000000);
        ID_UsesRT = 1'b1;
        chk("lu_rt_used", 7'b1110000);
        tick();

        clr();
        ID_Branch = 1'b1; ID_BranchTaken = 1'b1; EX_RegWrite = 1'b1; EX_RD = 5'd4; ID_RT = 5'd4;
        chk("br_ex_stall", 7'b1110000);
        tick();
        EX_RegWrite = 1'b0;
        chk("br_flush", 7'b0001000);
        tick();
        clr();
        ID_Branch = 1'b1; MEM_MemRead = 1'b1; MEM_RD = 5'd5; ID_RS = 5'd5;
        chk("br_mem_load", 7'b1110000);
        MEM_RD = 5'd0; ID_RS = 5'd0;
        chk("br_mem_r0", 7'b0000000);
        tick();

        clr();
        ID_MulDiv = 1'b1; EX_MemRead = 1'b1; EX_RD = 5'd3; ID_RS = 5'd3;
        chk("md_start_blocked_by_lu", 7'b1110000);
        tick();
        clr();
        chk("md_no_start_after_lu", 7'b0000000);

        ID_MulDiv = 1'b1; ID_IsDiv = 1'b1;
        chk("div_start", 7'b0000100);
        tick();
        clr();
        ID_ReadHiLo = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            chk($sformatf("div_busy_%0d", k), 7'b1110010);
            tick();
        end
        chk("div_done_mfhi_stall", 7'b1110011);
        tick();
        chk("div_mfhi_accept", 7'b0000000);
        tick();

        clr();
        ID_MulDiv = 1'b1;
        chk("mult1_start", 7'b0000100);
        tick();
        chk("mult2_stall_t1", 7'b1110010);
        tick();
        chk("mult2_stall_t2", 7'b1110010);
        tick();
        chk("mult2_stall_t3", 7'b1110010);
        tick();
        chk("mult2_stall_done", 7'b1110011);
        tick();
        chk("mult2_start", 7'b0000100);
        tick();
        clr();
        chk("mult2_busy_1", 7'b0000010);
        tick();
        chk("mult2_busy_2", 7'b0000010);
        tick();
        chk("mult2_busy_3", 7'b0000010);
        tick();
        chk("mult2_done", 7'b0000001 | 7'b0000010);
        tick();
        chk("mult2_idle", 7'b0000000);

        ID_MulDiv = 1'b1; ID_IsDiv = 1'b1;
        chk("rdiv_start", 7'b0000100);
        tick();
        clr();
        for (int k = 1; k <= 9; k++) tick();
        reset = 1'b1;
        chk("rdiv_busy_at_reset", 7'b0000010);
        tick();
        reset = 1'b0;
        ID_ReadHiLo = 1'b1;
        chk("rdiv_after_reset_mfhi", 7'b0000000);
        tick();
        clr();
        ID_MulDiv = 1'b1; ID_IsDiv = 1'b0;
        chk("restart_after_reset", 7'b0000100);
        tick();
        clr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
